bist_sequencer: RTL and testbench

Session controller for the 4-bit BIST datapath (pattern LFSR, input MUX, CUT, signature MISR). It owns the test-mode select and sequences one self-test session per `start` request. Each session seeds the LFSR, clears the MISR, applies a programmed number of patterns, then compares the captured signature against a programmable golden value. It replaces ad-hoc `testmode` driving and reports pass/fail, the captured signature and a saturating failure count.

---
 rtl/bist_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_bist_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: session controller for the 4-bit BIST datapath.
// Sequences IDLE -> INIT -> RUN (N cycles) -> SETTLE -> COMPARE per start
// request and drives the LFSR/MISR/MUX controls (Moore decode of state).
// Ports: clk, rst (sync, active-low); start/abort session control;
// cfg_we + cfg_patterns/cfg_golden/cfg_seed configuration (IDLE only);
// misr_sig signature input; testmode/lfsr_*/misr_* datapath controls;
// busy/done/aborted status; pass/fail/signature/fail_cnt results.
module bist_sequencer #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      CNT_W        = 8,
  parameter int unsigned      DEF_PATTERNS = 15,
  parameter logic [WIDTH-1:0] DEF_GOLDEN   = 4'b0100,
  parameter logic [WIDTH-1:0] DEF_SEED     = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_patterns,
  input  logic [WIDTH-1:0] cfg_golden,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] misr_sig,
  output logic             testmode,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_SETTLE,
    S_COMPARE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cfg_patterns_q, cfg_patterns_d;
  logic [WIDTH-1:0] cfg_golden_q, cfg_golden_d;
  logic [WIDTH-1:0] cfg_seed_q, cfg_seed_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] signature_q, signature_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;

  logic abort_hit;
  logic sig_match;

  assign abort_hit = abort && (state_q != S_IDLE);
  assign sig_match = (misr_sig == cfg_golden_q);

  // State register plus all session/config registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cfg_patterns_q <= CNT_W'(DEF_PATTERNS);
      cfg_golden_q   <= DEF_GOLDEN;
      cfg_seed_q     <= DEF_SEED;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      signature_q    <= '0;
      fail_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cfg_patterns_q <= cfg_patterns_d;
      cfg_golden_q   <= cfg_golden_d;
      cfg_seed_q     <= cfg_seed_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      signature_q    <= signature_d;
      fail_cnt_q     <= fail_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        // The counter is loaded on this edge, so decide from the config value.
        if (abort) begin
          state_d = S_IDLE;
        end else if (cfg_patterns_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = abort ? S_IDLE : S_COMPARE;
      end
      S_COMPARE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter, config and result registers. An abort suppresses every
  // state action, so results and counters hold and only aborted pulses.
  always_comb begin
    cnt_d          = cnt_q;
    cfg_patterns_d = cfg_patterns_q;
    cfg_golden_d   = cfg_golden_q;
    cfg_seed_d     = cfg_seed_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    pass_d         = pass_q;
    fail_d         = fail_q;
    signature_d    = signature_q;
    fail_cnt_d     = fail_cnt_q;
    if (abort_hit) begin
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            cfg_patterns_d = cfg_patterns;
            cfg_golden_d   = cfg_golden;
            cfg_seed_d     = cfg_seed;
          end
        end
        S_INIT: begin
          pass_d = 1'b0;
          fail_d = 1'b0;
          cnt_d  = cfg_patterns_q;
        end
        S_RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        S_COMPARE: begin
          signature_d = misr_sig;
          pass_d      = sig_match;
          fail_d      = !sig_match;
          done_d      = 1'b1;
          if (!sig_match && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore decode of datapath controls; forced low while reset is asserted.
  always_comb begin
    testmode  = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_INIT: begin
          testmode  = 1'b1;
          lfsr_load = 1'b1;
          misr_clr  = 1'b1;
        end
        S_RUN: begin
          testmode = 1'b1;
          lfsr_en  = 1'b1;
          misr_en  = 1'b1;
        end
        S_SETTLE, S_COMPARE: begin
          testmode = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign lfsr_seed = cfg_seed_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = signature_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_bist_sequencer.sv
module tb_bist_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_patterns = '0;
  logic [3:0] cfg_golden = '0;
  logic [3:0] cfg_seed = '0;
  logic [3:0] misr_sig = '0;
  logic       testmode, lfsr_load, lfsr_en, misr_clr, misr_en;
  logic [3:0] lfsr_seed, signature;
  logic       busy, done, aborted, pass, fail;
  logic [7:0] fail_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: configuration and last-session results.
  int unsigned m_patterns;
  logic [3:0]  m_golden, m_seed, m_sig;
  logic        m_pass, m_fail;
  int unsigned m_fail_cnt;

  bist_sequencer #(
    .WIDTH(4),
    .CNT_W(8),
    .DEF_PATTERNS(15),
    .DEF_GOLDEN(4'b0100),
    .DEF_SEED(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_we(cfg_we),
    .cfg_patterns(cfg_patterns), .cfg_golden(cfg_golden), .cfg_seed(cfg_seed),
    .misr_sig(misr_sig), .testmode(testmode), .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en), .misr_clr(misr_clr),
    .misr_en(misr_en), .busy(busy), .done(done), .aborted(aborted),
    .pass(pass), .fail(fail), .signature(signature), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_patterns = 15;
    m_golden   = 4'b0100;
    m_seed     = 4'hF;
    m_sig      = 4'h0;
    m_pass     = 1'b0;
    m_fail     = 1'b0;
    m_fail_cnt = 0;
  endtask

  task automatic cfg_load(input logic [7:0] p, input logic [3:0] g, input logic [3:0] s);
    start = 1'b0;
    abort = 1'b0;
    cfg_we = 1'b1;
    cfg_patterns = p;
    cfg_golden = g;
    cfg_seed = s;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_patterns = p;
    m_golden = g;
    m_seed = s;
  endtask

  // One session starting from an idle cycle. Cycle k counts clock periods
  // after the start edge: 0 = INIT, 1..N = RUN, N+1 = SETTLE, N+2 = COMPARE,
  // N+3 = first idle cycle carrying done. abort_at >= 1 aborts during cycle
  // abort_at; noise writes cfg (patterns=3) throughout the busy period.
  task automatic run_session(input string tag, input logic [3:0] cmp_val,
                             input int abort_at, input bit noise, input bit hold_start);
    int n;
    int last;
    bit ab;
    bit in_sess;
    logic [9:0]  exp_c, got_c;
    logic [15:0] exp_r, got_r;
    n = int'(m_patterns);
    ab = (abort_at >= 1) && (abort_at <= n + 2);
    last = ab ? abort_at + 1 : n + 3;
    start = 1'b1;
    abort = 1'b0;
    cfg_we = 1'b0;
    misr_sig = 4'($urandom);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      in_sess = (k <= n + 2) && !(ab && k > abort_at);
      if (k == 1) begin
        m_pass = 1'b0;
        m_fail = 1'b0;
      end
      if (k == last && !ab) begin
        m_sig  = cmp_val;
        m_pass = (cmp_val == m_golden);
        m_fail = !m_pass;
        if (m_fail && m_fail_cnt < 255) m_fail_cnt++;
      end
      exp_c = {in_sess, in_sess && k == 0, in_sess && k >= 1 && k <= n,
               in_sess && k == 0, in_sess && k >= 1 && k <= n, in_sess,
               !ab && k == n + 3, ab && k == abort_at + 1, m_pass, m_fail};
      got_c = {testmode, lfsr_load, lfsr_en, misr_clr, misr_en, busy,
               done, aborted, pass, fail};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL %s ctrl k=%0d n=%0d: got %b expected %b (tm,ld,len,clr,men,busy,done,abt,pass,fail)",
                 tag, k, n, got_c, exp_c);
      end
      exp_r = {m_sig, 8'(m_fail_cnt), m_seed};
      got_r = {signature, fail_cnt, lfsr_seed};
      checks++;
      if (got_r !== exp_r) begin
        failures++;
        $display("FAIL %s result k=%0d: got sig=%h cnt=%0d seed=%h expected sig=%h cnt=%0d seed=%h",
                 tag, k, got_r[15:12], got_r[11:4], got_r[3:0],
                 exp_r[15:12], exp_r[11:4], exp_r[3:0]);
      end
      if (k < last) begin
        misr_sig = (k == n + 2) ? cmp_val : 4'($urandom);
        abort = ab && (k == abort_at);
        if (noise && in_sess) begin
          cfg_we = 1'b1;
          cfg_patterns = 8'd3;
          cfg_golden = 4'($urandom);
          cfg_seed = 4'($urandom);
        end else begin
          cfg_we = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    abort = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({testmode, lfsr_load, lfsr_en, misr_clr, misr_en, busy, done, aborted, pass, fail} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {testmode, lfsr_load, lfsr_en, misr_clr,
               misr_en, busy, done, aborted, pass, fail});
    end
    checks++;
    if ({signature, fail_cnt, lfsr_seed} !== {4'h0, 8'd0, 4'hF}) begin
      failures++;
      $display("FAIL reset_regs: got sig=%h cnt=%0d seed=%h expected sig=0 cnt=0 seed=f",
               signature, fail_cnt, lfsr_seed);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal_pass();
    run_session("nominal", 4'b0100, -1, 1'b0, 1'b0);
    checks++;
    if ({pass, fail, signature} !== {1'b1, 1'b0, 4'b0100}) begin
      failures++;
      $display("FAIL nominal_result: got pass=%b fail=%b sig=%h expected pass=1 fail=0 sig=4",
               pass, fail, signature);
    end
  endtask

  task automatic test_fail_path();
    cfg_load(8'd15, 4'b1010, 4'hF);
    run_session("fail_first", 4'b0100, -1, 1'b0, 1'b0);
    checks++;
    if ({fail, fail_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL fail_first: got fail=%b cnt=%0d expected fail=1 cnt=1", fail, fail_cnt);
    end
    cfg_load(8'd1, 4'b1010, 4'h3);
    for (int i = 0; i < 259; i++) begin
      run_session("fail_sat", 4'b0100, -1, 1'b0, 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    checks++;
    if (fail_cnt !== 8'd255) begin
      failures++;
      $display("FAIL fail_saturate: got cnt=%0d expected 255", fail_cnt);
    end
  endtask

  task automatic test_abort();
    cfg_load(8'd15, 4'b0100, 4'hF);
    run_session("abort_pre", 4'b0100, -1, 1'b0, 1'b0);
    run_session("abort_run5", 4'b1111, 5, 1'b0, 1'b0);
    checks++;
    if ({pass, fail, signature, busy} !== {1'b0, 1'b0, 4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL abort_result: got pass=%b fail=%b sig=%h busy=%b expected 0 0 4 0",
               pass, fail, signature, busy);
    end
    run_session("abort_compare", 4'b0001, 17, 1'b0, 1'b0);
  endtask

  task automatic test_zero_patterns();
    cfg_load(8'd0, 4'b0000, 4'($urandom));
    run_session("zero_pat", 4'b0000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cfg_load(8'd4, 4'b0110, 4'h9);
    run_session("b2b_1", 4'b0110, -1, 1'b0, 1'b1);
    run_session("b2b_2", 4'b0111, -1, 1'b0, 1'b1);
    run_session("b2b_3", 4'b0110, -1, 1'b0, 1'b0);
  endtask

  task automatic test_collisions();
    cfg_load(8'd15, 4'b0100, 4'hF);
    run_session("cfg_we_busy", 4'b0100, -1, 1'b1, 1'b0);
    run_session("cfg_kept", 4'b0100, -1, 1'b0, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, testmode, done, aborted} !== 4'b0) begin
        failures++;
        $display("FAIL start_abort_idle c=%0d: got busy,tm,done,abt=%b expected 0000",
                 i, {busy, testmode, done, aborted});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    cfg_load(8'd10, 4'h3, 4'h5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({testmode, lfsr_load, lfsr_en, misr_clr, misr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_gating: got tm,ld,len,clr,men=%b expected 00000",
               {testmode, lfsr_load, lfsr_en, misr_clr, misr_en});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    checks++;
    if ({busy, done, aborted, pass, fail, signature, fail_cnt, lfsr_seed} !== {5'b0, 4'h0, 8'd0, 4'hF}) begin
      failures++;
      $display("FAIL reset_mid_run: got busy=%b done=%b abt=%b pass=%b fail=%b sig=%h cnt=%0d seed=%h expected 0 0 0 0 0 0 0 f",
               busy, done, aborted, pass, fail, signature, fail_cnt, lfsr_seed);
    end
    run_session("after_reset", 4'b0100, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    int ab;
    logic [3:0] cmp;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_load(8'($urandom_range(0, 20)), 4'($urandom), 4'($urandom));
      end
      n = int'(m_patterns);
      cmp = ($urandom_range(0, 1) == 1) ? m_golden : 4'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + 2)) : -1;
      run_session("random", cmp, ab, 1'($urandom_range(0, 1)),
                  (s != 39) && ($urandom_range(0, 1) == 1));
    end
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal_pass();
    test_fail_path();
    test_abort();
    test_zero_patterns();
    test_back_to_back();
    test_collisions();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
